// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four masters and the arbiter.
//   req     - request vector, bit i = requester i (driven by the masters)
//   gnt_idx - registered index of the current grantee
//   gnt_en  - registered, 1 while a grant is active
//   gnt     - one-hot grant decoded from {gnt_en, gnt_idx}
//   busy    - copy of gnt_en for the resource side
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_en;
  logic [3:0] gnt;
  logic       busy;

  modport master (output req, input gnt_idx, gnt_en, gnt, busy);
  modport slave  (input req, output gnt_idx, gnt_en, gnt, busy);
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a bounded hold time
// per grant and a one-cycle dead cycle (gnt_en=0) on every handover.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset
//   bus - rr_arbiter4_if.slave (req in; gnt_idx, gnt_en, gnt, busy out)
// Parameter:
//   MAX_HOLD - maximum consecutive grant cycles per requester (1..255)
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic       en_reg, en_next;
  logic [1:0] last_reg, last_next;
  logic [7:0] hold_reg, hold_next;

  logic [1:0] winner;
  logic       found;
  logic [1:0] cand;
  logic       release_now;

  // Round-robin search. Walking the candidates from lowest priority
  // (last_reg itself, offset 4) up to highest (offset 1) lets the last
  // matching assignment be the winner without any early exit.
  always_comb begin
    winner = last_reg;
    found  = 1'b0;
    cand   = last_reg;
    for (int k = 4; k >= 1; k--) begin
      cand = last_reg + k[1:0];
      if (bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // hold_reg counts completed grant cycles minus one, so reaching
  // MAX_HOLD-1 means this cycle is the last one the grantee may keep.
  assign release_now = !bus.req[idx_reg] || (hold_reg == 8'(MAX_HOLD - 1));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    en_next    = en_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        en_next = 1'b0;
        if (found) begin
          idx_next   = winner;
          en_next    = 1'b1;
          hold_next  = 8'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // gnt_idx is left as-is; only the enable drops.
          en_next    = 1'b0;
          last_next  = idx_reg;
          hold_next  = 8'd0;
          state_next = IDLE;
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 2'b00;
      en_reg    <= 1'b0;
      last_reg  <= 2'b11;   // requester 0 is first after reset
      hold_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      en_reg    <= en_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
    end
  end

  // One-hot decode of registered state only; no path from req to outputs.
  for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
    assign bus.gnt[gi] = en_reg && (idx_reg == 2'(gi));
  end

  assign bus.gnt_idx = idx_reg;
  assign bus.gnt_en  = en_reg;
  assign bus.busy    = en_reg;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares a single decoded resource (one-hot select lines) among four masters. It sits in front of the 2-to-4 select decoding in the combinational library. It registers a 2-bit grant index plus enable and drives the one-hot grant from them. It enforces a bounded hold time per grant and a one-cycle dead cycle on every handover.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant; legal range 1..255.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i; level-sensitive, sampled on clk.
- gnt_idx  output  2  registered index of the current grantee.
- gnt_en  output  1  registered; 1 while a grant is active.
- gnt  output  4  one-hot grant, decoded from {gnt_en, gnt_idx}; bit gnt_idx is 1 when gnt_en=1, else 4'b0000.
- busy  output  1  equal to gnt_en; provided for the resource side.

## Operation
- State register has two states, IDLE and GRANT. Internal registers: last_idx[1:0] and hold_cnt[7:0].
- Reset values, applied asynchronously while rst=1:
  - State = IDLE; gnt_en=0; gnt_idx=2'b00; gnt=4'b0000; busy=0.
  - last_idx=2'b11, so requester 0 has first priority. hold_cnt=0.
- Priority search: candidates are checked in the order last_idx+1, +2, +3, +4 (mod 4). The first candidate with its req bit set wins. last_idx itself is lowest priority.
- IDLE:
  - req==0: stay in IDLE, gnt_en=0.
  - req!=0: at the next edge, gnt_idx = winner, gnt_en=1, hold_cnt=0, state goes to GRANT.
- GRANT: each cycle, evaluate in this order.
  - Release if req[gnt_idx]==0, or if hold_cnt==MAX_HOLD-1.
  - On release, at the next edge: gnt_en=0, last_idx=gnt_idx, hold_cnt=0, state goes to IDLE. gnt_idx keeps its value.
  - Otherwise hold_cnt increments by 1 and the grant is held.
- Every handover passes through one IDLE cycle with gnt_en=0 (dead cycle), including re-grant to the same requester.
- Re-arbitration in IDLE uses the updated last_idx. A requester forced off by MAX_HOLD therefore goes behind every other active requester.
- MAX_HOLD=1 means every grant lasts exactly one cycle.
- hold_cnt never exceeds MAX_HOLD-1 and never wraps.
- gnt is a pure decode of registered state. Its bits are never 1 when gnt_en=0, and at most one bit is 1.
- A req bit set only during the dead cycle is sampled normally in IDLE.
- A req pulse that rises and falls within a GRANT period for another index is lost; requesters must hold req until granted.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. req is sampled at edge N; gnt_en=1 after edge N.
- Grant release: req[gnt_idx] falls before edge N, and gnt_en=0 after edge N.
- Forced release: a requester granted after edge N, with req held, loses the grant after edge N+MAX_HOLD. It holds the grant for MAX_HOLD cycles.
- Back-to-back handover: grant(A) for k cycles, 1 dead cycle, then grant(B). The period per grant under full load is MAX_HOLD+1 cycles.
- Asynchronous rst mid-grant clears gnt/gnt_en immediately, without waiting for clk. After rst deasserts, the first arbitration again favors requester 0.
- Outputs are registered or decoded from registers. There is no combinational path from req to outputs.

## Test plan
- Reset: assert rst mid-cycle with req=4'b1111 → gnt=0000, gnt_en=0, gnt_idx=00 immediately. After release, the first grant is gnt=0001.
- Single requester: req=0100 held 3 cycles, then 0 → gnt=0100 starting one cycle after req rises, held 3 cycles, then 0000 one cycle after req falls.
- Full load, MAX_HOLD=2, req=1111 constant → gnt sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001.
- Rotation skip: last_idx=1 (after serving requester 1), req=1011 → next grant is 1000, then 0001, then 0010.
- Hold limit: MAX_HOLD=3, req=0001 only, held continuously → gnt=0001 for 3 cycles, 0000 for 1 cycle, repeating; no cycle ever shows 2+ bits set.
- MAX_HOLD=1, req=0110 constant → gnt alternates 0010,0000,0100,0000,0010; async rst during a 0100 cycle → 0000 immediately, next grant is 0010.
